// File: rtl/serdesphy_pkg.sv
// Shared types and widths for the SerDes PHY link sequencer.
//   state_e  : FSM state encoding (also the CSR readback code)
//   STATE_W  : width of the state code
//   RETRY_W  : width of the retry counter
package serdesphy_pkg;

  localparam int unsigned STATE_W = 3;
  localparam int unsigned RETRY_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_OFF      = 3'd0,
    ST_PLL_WAIT = 3'd1,
    ST_CDR_WAIT = 3'd2,
    ST_PRBS_CHK = 3'd3,
    ST_LINK_UP  = 3'd4,
    ST_RETRY    = 3'd5,
    ST_FAULT    = 3'd6
  } state_e;

  localparam logic [RETRY_W-1:0] RETRY_SAT = '1;

  // Saturating increment of the retry counter.
  function automatic logic [RETRY_W-1:0] retry_inc(input logic [RETRY_W-1:0] cnt);
    return (cnt == RETRY_SAT) ? cnt : cnt + RETRY_W'(1);
  endfunction

endpackage

// File: rtl/serdesphy_lock_filter.sv
// Consecutive-sample debounce for a synchronised lock indicator.
//   clk, rst_n  : reference clock, synchronous active-low reset
//   clr_i       : clear both run counters (state change in the sequencer)
//   in_i        : raw lock indicator
//   locked_c_o  : in_i has been high for N consecutive cycles, this one included
//   lost_c_o    : in_i has been low for N consecutive cycles, this one included
module serdesphy_lock_filter #(
  parameter int unsigned N = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic in_i,
  output logic locked_c_o,
  output logic lost_c_o
);

  localparam int unsigned CW = $clog2(N + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(N);
  localparam logic [CW-1:0] CNT_THR = CW'(N - 1);

  logic [CW-1:0] hi_cnt_q, hi_cnt_d;
  logic [CW-1:0] lo_cnt_q, lo_cnt_d;

  // Run-length counters; saturate at N so the qualified level holds.
  always_comb begin
    hi_cnt_d = hi_cnt_q;
    lo_cnt_d = lo_cnt_q;
    if (clr_i) begin
      hi_cnt_d = '0;
      lo_cnt_d = '0;
    end else if (in_i) begin
      lo_cnt_d = '0;
      hi_cnt_d = (hi_cnt_q == CNT_MAX) ? hi_cnt_q : hi_cnt_q + CW'(1);
    end else begin
      hi_cnt_d = '0;
      lo_cnt_d = (lo_cnt_q == CNT_MAX) ? lo_cnt_q : lo_cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hi_cnt_q <= '0;
      lo_cnt_q <= '0;
    end else begin
      hi_cnt_q <= hi_cnt_d;
      lo_cnt_q <= lo_cnt_d;
    end
  end

  // Current sample completes the run, so the FSM can act in the same cycle.
  assign locked_c_o = in_i  && (hi_cnt_q >= CNT_THR);
  assign lost_c_o   = !in_i && (lo_cnt_q >= CNT_THR);

endmodule

// File: rtl/serdesphy_link_sequencer.sv
// Bring-up / recovery sequencer for the SerDes PHY link (24 MHz reference domain).
// Sequences PLL, TX/RX/CDR enables, PRBS qualification and link-up; retrains on
// loss of lock and latches a fault once the retry budget is exhausted.
//   clk, rst_n          : reference clock, synchronous active-low reset
//   enable, lpbk_req    : CSR link enable (level) and loopback request
//   pll_lock, cdr_lock  : synchronised lock indicators
//   prbs_err            : PRBS checker error pulse
//   pll_en .. fault     : registered Moore decodes of the state
//   state, retry_cnt    : CSR readback of state code and failed attempts
module serdesphy_link_sequencer
  import serdesphy_pkg::*;
#(
  parameter int unsigned PLL_TIMEOUT       = 4096,
  parameter int unsigned CDR_TIMEOUT       = 8192,
  parameter int unsigned PRBS_CHECK_CYCLES = 1024,
  parameter int unsigned LOCK_FILTER       = 16,
  parameter int unsigned MAX_RETRIES       = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic               lpbk_req,
  input  logic               pll_lock,
  input  logic               cdr_lock,
  input  logic               prbs_err,
  output logic               pll_en,
  output logic               txrx_en,
  output logic               cdr_en,
  output logic               prbs_en,
  output logic               lpbk_en,
  output logic               link_up,
  output logic               fault,
  output logic [STATE_W-1:0] state,
  output logic [RETRY_W-1:0] retry_cnt
);

  localparam int unsigned TMAX_A = (PLL_TIMEOUT > CDR_TIMEOUT) ? PLL_TIMEOUT : CDR_TIMEOUT;
  localparam int unsigned TMAX   = (TMAX_A > PRBS_CHECK_CYCLES) ? TMAX_A : PRBS_CHECK_CYCLES;
  localparam int unsigned TW     = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [TW-1:0]      PLL_LAST   = TW'(PLL_TIMEOUT - 1);
  localparam logic [TW-1:0]      CDR_LAST   = TW'(CDR_TIMEOUT - 1);
  localparam logic [TW-1:0]      PRBS_LAST  = TW'(PRBS_CHECK_CYCLES - 1);
  localparam logic [TW-1:0]      RETRY_LAST = TW'(LOCK_FILTER - 1);
  localparam logic [RETRY_W-1:0] RETRY_LIM  = RETRY_W'(MAX_RETRIES);

  state_e             state_q, state_d;
  logic [TW-1:0]      timer_q, timer_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic               lpbk_q, lpbk_d;
  logic               state_chg;

  logic pll_en_q, pll_en_d, txrx_en_q, txrx_en_d, cdr_en_q, cdr_en_d;
  logic prbs_en_q, prbs_en_d, lpbk_en_q, lpbk_en_d;
  logic link_up_q, link_up_d, fault_q, fault_d;

  logic pll_locked, pll_lost_unused;
  logic cdr_locked, cdr_lost;

  assign state_chg = (state_d != state_q);

  serdesphy_lock_filter #(.N(LOCK_FILTER)) u_pll_filt (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (state_chg),
    .in_i       (pll_lock),
    .locked_c_o (pll_locked),
    .lost_c_o   (pll_lost_unused)
  );

  serdesphy_lock_filter #(.N(LOCK_FILTER)) u_cdr_filt (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (state_chg),
    .in_i       (cdr_lock),
    .locked_c_o (cdr_locked),
    .lost_c_o   (cdr_lost)
  );

  // Next-state: enable=0 dominates, then lock/error events, then timeouts.
  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = ST_OFF;
    end else begin
      case (state_q)
        ST_OFF:      state_d = ST_PLL_WAIT;
        ST_PLL_WAIT: begin
          if (pll_locked)              state_d = ST_CDR_WAIT;
          else if (timer_q == PLL_LAST) state_d = ST_RETRY;
        end
        ST_CDR_WAIT: begin
          if (cdr_locked)              state_d = ST_PRBS_CHK;
          else if (!pll_lock)          state_d = ST_RETRY;
          else if (timer_q == CDR_LAST) state_d = ST_RETRY;
        end
        ST_PRBS_CHK: begin
          if (prbs_err)                 state_d = ST_RETRY;
          else if (timer_q == PRBS_LAST) state_d = ST_LINK_UP;
        end
        ST_LINK_UP: begin
          if (!pll_lock || cdr_lost) state_d = ST_RETRY;
        end
        ST_RETRY: begin
          // retry_q already holds the count including this attempt.
          if (timer_q == RETRY_LAST)
            state_d = (retry_q >= RETRY_LIM) ? ST_FAULT : ST_PLL_WAIT;
        end
        ST_FAULT:    state_d = ST_FAULT;
        default:     state_d = ST_OFF;
      endcase
    end
  end

  // Timer, retry counter and loopback latch.
  always_comb begin
    timer_d = state_chg ? '0 : ((timer_q == '1) ? timer_q : timer_q + TW'(1));

    retry_d = retry_q;
    if (state_d == ST_OFF || (state_d == ST_LINK_UP && state_q != ST_LINK_UP))
      retry_d = '0;
    else if (state_d == ST_RETRY && state_q != ST_RETRY)
      retry_d = retry_inc(retry_q);

    lpbk_d = lpbk_q;
    if (state_d == ST_CDR_WAIT && state_q != ST_CDR_WAIT)
      lpbk_d = lpbk_req;
  end

  // Output decode from the next state so registered outputs track state_q.
  always_comb begin
    pll_en_d  = state_d inside {ST_PLL_WAIT, ST_CDR_WAIT, ST_PRBS_CHK, ST_LINK_UP};
    txrx_en_d = state_d inside {ST_CDR_WAIT, ST_PRBS_CHK, ST_LINK_UP};
    cdr_en_d  = txrx_en_d;
    prbs_en_d = (state_d == ST_PRBS_CHK);
    lpbk_en_d = txrx_en_d && lpbk_d;
    link_up_d = (state_d == ST_LINK_UP);
    fault_d   = (state_d == ST_FAULT);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_OFF;
      timer_q   <= '0;
      retry_q   <= '0;
      lpbk_q    <= 1'b0;
      pll_en_q  <= 1'b0;
      txrx_en_q <= 1'b0;
      cdr_en_q  <= 1'b0;
      prbs_en_q <= 1'b0;
      lpbk_en_q <= 1'b0;
      link_up_q <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      retry_q   <= retry_d;
      lpbk_q    <= lpbk_d;
      pll_en_q  <= pll_en_d;
      txrx_en_q <= txrx_en_d;
      cdr_en_q  <= cdr_en_d;
      prbs_en_q <= prbs_en_d;
      lpbk_en_q <= lpbk_en_d;
      link_up_q <= link_up_d;
      fault_q   <= fault_d;
    end
  end

  assign pll_en    = pll_en_q;
  assign txrx_en   = txrx_en_q;
  assign cdr_en    = cdr_en_q;
  assign prbs_en   = prbs_en_q;
  assign lpbk_en   = lpbk_en_q;
  assign link_up   = link_up_q;
  assign fault     = fault_q;
  assign state     = state_q;
  assign retry_cnt = retry_q;

endmodule
